// File: rtl/ultrasound_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ultrasound_scheduler
// Description : Round-robin trigger/measurement engine shared by NUM_SENSORS
//               HC-SR04-style ultrasound sensors. Each slot issues one trigger
//               pulse, times the echo, latches a detection/timeout result for
//               that sensor and then waits out a holdoff gap before moving on.
// Ports       : clk             - system clock
//               rst_n           - asynchronous active-low reset
//               enable          - run the scan while high
//               echo            - raw (asynchronous) echo pins
//               trigger         - trigger pins, at most one high at a time
//               object_detected - per-sensor latched detection result
//               timeout_flag    - per-sensor latched timeout result
//               meas_valid      - one-cycle strobe, new result for sensor_id
//               sensor_id       - slot of the current or last measurement
//               pulse_width     - echo width (cycles) of the last measurement
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasound_scheduler #(
  parameter int NUM_SENSORS         = 4,
  parameter int TRIG_CYCLES         = 500,
  parameter int ECHO_TIMEOUT_CYCLES = 1500000,
  parameter int HOLDOFF_CYCLES      = 3000000,
  parameter int THRESH_CYCLES       = 58823,
  parameter int CNT_W               = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_SENSORS-1:0]         echo,
  output logic [NUM_SENSORS-1:0]         trigger,
  output logic [NUM_SENSORS-1:0]         object_detected,
  output logic [NUM_SENSORS-1:0]         timeout_flag,
  output logic                           meas_valid,
  output logic [$clog2(NUM_SENSORS)-1:0] sensor_id,
  output logic [CNT_W-1:0]               pulse_width
);

  localparam int SLOT_W = $clog2(NUM_SENSORS);

  localparam logic [CNT_W-1:0]  TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL  = CNT_W'(ECHO_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  THRESH       = CNT_W'(THRESH_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [SLOT_W-1:0] SLOT_LAST    = SLOT_W'(NUM_SENSORS - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  logic rst_n_meta_q, rst_n_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_n_meta_q <= 1'b0;
      rst_n_sync_q <= 1'b0;
    end else begin
      rst_n_meta_q <= 1'b1;
      rst_n_sync_q <= rst_n_meta_q;
    end
  end

  // Two-flop synchronizer per echo pin.
  logic [NUM_SENSORS-1:0] echo_meta_q, echo_sync_q, echo_prev_q;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_echo_sync
    always_ff @(posedge clk or negedge rst_n_sync_q) begin
      if (!rst_n_sync_q) begin
        echo_meta_q[i] <= 1'b0;
        echo_sync_q[i] <= 1'b0;
        echo_prev_q[i] <= 1'b0;
      end else begin
        echo_meta_q[i] <= echo[i];
        echo_sync_q[i] <= echo_meta_q[i];
        echo_prev_q[i] <= echo_sync_q[i];
      end
    end
  end

  logic [2:0]             state_q, state_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0] trigger_q, trigger_d;
  logic [NUM_SENSORS-1:0] object_detected_q, object_detected_d;
  logic [NUM_SENSORS-1:0] timeout_flag_q, timeout_flag_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]       pulse_width_q, pulse_width_d;

  logic              echo_cur, echo_rise, do_timeout, do_result;
  logic [CNT_W-1:0]  cnt_inc;
  logic [SLOT_W-1:0] slot_next;

  always_comb begin
    state_d           = state_q;
    slot_d            = slot_q;
    cnt_d             = cnt_q;
    trigger_d         = trigger_q;
    object_detected_d = object_detected_q;
    timeout_flag_d    = timeout_flag_q;
    meas_valid_d      = 1'b0;
    pulse_width_d     = pulse_width_q;
    do_timeout        = 1'b0;
    do_result         = 1'b0;

    // Only the active slot's echo is looked at; a rising edge needs the
    // previous synchronized sample low, so an echo already high is ignored.
    echo_cur  = echo_sync_q[slot_q];
    echo_rise = echo_cur & ~echo_prev_q[slot_q];
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    slot_next = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        trigger_d = '0;
        if (enable) begin
          state_d           = ST_TRIG;
          cnt_d             = '0;
          trigger_d[slot_q] = 1'b1;
        end
      end
      ST_TRIG: begin
        if (cnt_q >= TRIG_LAST) begin
          trigger_d = '0;
          state_d   = ST_WAIT;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT: begin
        if (echo_rise) begin
          state_d = ST_MEASURE;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q >= TIMEOUT_LAST) begin
          do_timeout = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_MEASURE: begin
        if (!echo_cur) begin
          do_result = 1'b1;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          do_timeout = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q >= HOLD_LAST) begin
          slot_d = slot_next;
          cnt_d  = '0;
          // Trigger pulses only ever start here or in IDLE, so dropping
          // enable can never cut one short.
          if (enable) begin
            state_d              = ST_TRIG;
            trigger_d            = '0;
            trigger_d[slot_next] = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        trigger_d = '0;
        cnt_d     = '0;
      end
    endcase

    if (do_result) begin
      pulse_width_d             = cnt_q;
      object_detected_d[slot_q] = (cnt_q <= THRESH);
      timeout_flag_d[slot_q]    = 1'b0;
    end
    if (do_timeout) begin
      pulse_width_d             = TIMEOUT_VAL;
      object_detected_d[slot_q] = 1'b0;
      timeout_flag_d[slot_q]    = 1'b1;
    end
    if (do_result || do_timeout) begin
      meas_valid_d = 1'b1;
      state_d      = ST_HOLDOFF;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync_q) begin
    if (!rst_n_sync_q) begin
      state_q           <= ST_IDLE;
      slot_q            <= '0;
      cnt_q             <= '0;
      trigger_q         <= '0;
      object_detected_q <= '0;
      timeout_flag_q    <= '0;
      meas_valid_q      <= 1'b0;
      pulse_width_q     <= '0;
    end else begin
      state_q           <= state_d;
      slot_q            <= slot_d;
      cnt_q             <= cnt_d;
      trigger_q         <= trigger_d;
      object_detected_q <= object_detected_d;
      timeout_flag_q    <= timeout_flag_d;
      meas_valid_q      <= meas_valid_d;
      pulse_width_q     <= pulse_width_d;
    end
  end

  assign trigger         = trigger_q;
  assign object_detected = object_detected_q;
  assign timeout_flag    = timeout_flag_q;
  assign meas_valid      = meas_valid_q;
  assign sensor_id       = slot_q;
  assign pulse_width     = pulse_width_q;

endmodule
`default_nettype wire

// File: tb/tb_ultrasound_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultrasound_scheduler
// Description : Self-checking bench for ultrasound_scheduler. Drives echo
//               pulses per slot and compares every result against a
//               slot-level model of the scan rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasound_scheduler;

  localparam int N    = 4;
  localparam int TRIG = 5;
  localparam int TO   = 100;
  localparam int HOLD = 10;
  localparam int TH   = 40;
  localparam int CW   = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [N-1:0]  echo = '0;
  logic [N-1:0]  trigger, object_detected, timeout_flag;
  logic          meas_valid;
  logic [1:0]    sensor_id;
  logic [CW-1:0] pulse_width;

  ultrasound_scheduler #(
    .NUM_SENSORS(N), .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HOLD), .THRESH_CYCLES(TH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
    .trigger(trigger), .object_detected(object_detected),
    .timeout_flag(timeout_flag), .meas_valid(meas_valid),
    .sensor_id(sensor_id), .pulse_width(pulse_width)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: latched result bits per sensor and the expected slot.
  logic [N-1:0] m_det = '0;
  logic [N-1:0] m_tmo = '0;
  int           exp_slot = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_trigger(input string tag);
    int g = 0;
    while (trigger == '0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check_val(tag, 32'(trigger != '0), 32'd1);
  endtask

  // One slot: kind 0 = pulse (dly, wid), 1 = no echo, 2 = echo stuck high.
  // Entered on the first negedge where the trigger is high.
  task automatic run_slot(input int kind, input int dly, input int wid,
                          input bit noise, input bit drop_en);
    int          hi, t, g, other;
    bit          seen, bad, exp_to, exp_det;
    logic [31:0] exp_trig, exp_pw;
    exp_trig = 32'd1 << exp_slot;
    other    = (exp_slot + 1) % N;
    if (kind == 2) echo[exp_slot] = 1'b1;
    check_val("trig_onehot", 32'(trigger), exp_trig);
    check_val("sid_trig", 32'(sensor_id), 32'(exp_slot));
    hi  = 0;
    bad = 1'b0;
    while (trigger != '0 && hi < 50) begin
      if (32'(trigger) != exp_trig) bad = 1'b1;
      hi++;
      @(negedge clk);
    end
    check_val("trig_bits", 32'(bad), 32'd0);
    check_val("trig_len", 32'(hi), 32'(TRIG));

    seen = 1'b0;
    t    = 0;
    while (!seen && t < 400) begin
      if (meas_valid) begin
        seen = 1'b1;
      end else begin
        if (kind == 0) echo[exp_slot] = (t >= dly && t < dly + wid);
        if (noise) echo[other] = 1'($urandom_range(0, 1));
        if (drop_en && t == dly + 10) enable = 1'b0;
        @(negedge clk);
        t++;
      end
    end
    echo[exp_slot] = 1'b0;
    if (noise) echo[other] = 1'b0;

    if (kind == 0 && wid < TO) begin
      exp_pw = 32'(wid); exp_to = 1'b0; exp_det = (wid <= TH);
    end else begin
      exp_pw = 32'(TO);  exp_to = 1'b1; exp_det = 1'b0;
    end
    m_det[exp_slot] = exp_det;
    m_tmo[exp_slot] = exp_to;

    check_val("mv_seen", 32'(seen), 32'd1);
    check_val("sid_mv", 32'(sensor_id), 32'(exp_slot));
    check_val("pulse_width", 32'(pulse_width), exp_pw);
    check_val("obj_det", 32'(object_detected), 32'(m_det));
    check_val("tmo_flag", 32'(timeout_flag), 32'(m_tmo));
    if (kind == 1) check_val("wait_tmo_lat", 32'(t), 32'(TO));

    g = 0;
    while (g < 40) begin
      @(negedge clk);
      g++;
      if (g == 1) check_val("mv_strobe", 32'(meas_valid), 32'd0);
      if (trigger != '0) break;
    end
    exp_slot = (exp_slot + 1) % N;
    if (drop_en) check_val("idle_no_trig", 32'(trigger), 32'd0);
    else         check_val("holdoff_gap", 32'(g), 32'(HOLD));
    check_val("sid_adv", 32'(sensor_id), 32'(exp_slot));
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_val("rst_trig", 32'(trigger), 32'd0);
    check_val("rst_det", 32'(object_detected), 32'd0);
    check_val("rst_tmo", 32'(timeout_flag), 32'd0);
    check_val("rst_mv", 32'(meas_valid), 32'd0);
    check_val("rst_sid", 32'(sensor_id), 32'd0);
    check_val("rst_pw", 32'(pulse_width), 32'd0);

    rst_n  = 1'b1;
    enable = 1'b1;
    wait_trigger("start_trig");

    run_slot(0, 3, 30, 1'b0, 1'b0);
    run_slot(0, 5, 60, 1'b0, 1'b0);
    run_slot(1, 0, 0, 1'b0, 1'b0);
    run_slot(2, 0, 0, 1'b0, 1'b0);
    run_slot(0, 2, 40, 1'b1, 1'b0);
    run_slot(0, 4, 41, 1'b0, 1'b0);
    run_slot(0, 1, 99, 1'b0, 1'b0);
    run_slot(0, 1, 100, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      k = int'($urandom_range(0, 4));
      run_slot((k < 3) ? 0 : k - 2, int'($urandom_range(1, 40)),
               int'($urandom_range(1, 120)), 1'($urandom_range(0, 1)), 1'b0);
    end

    run_slot(0, 3, 50, 1'b0, 1'b1);

    enable = 1'b1;
    wait_trigger("restart_trig");
    check_val("restart_slot", 32'(trigger), 32'd1 << exp_slot);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst2_trig", 32'(trigger), 32'd0);
    check_val("rst2_det", 32'(object_detected), 32'd0);
    check_val("rst2_tmo", 32'(timeout_flag), 32'd0);
    check_val("rst2_sid", 32'(sensor_id), 32'd0);
    check_val("rst2_pw", 32'(pulse_width), 32'd0);
    m_det    = '0;
    m_tmo    = '0;
    exp_slot = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_trigger("post_rst_trig");
    run_slot(0, 2, 20, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ultrasound_scheduler.md
Name: ultrasound_scheduler

Overview:
- Time-multiplexes one trigger/measurement engine across NUM_SENSORS HC-SR04-style ultrasound sensors, in round-robin order.
- For each slot it issues a trigger pulse, measures the echo width, flags timeouts and updates the per-sensor object_detected bit.
- It then waits out a holdoff period so echoes from one sensor cannot corrupt the next.
- Sits between the sensor pins and the game/display logic, replacing free-running per-sensor trigger logic.

Parameters:
NUM_SENSORS, 4, number of sensors served (>=2)
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
ECHO_TIMEOUT_CYCLES, 1500000, max cycles waiting for or measuring echo (30 ms)
HOLDOFF_CYCLES, 3000000, quiet gap after each measurement (60 ms)
THRESH_CYCLES, 58823, echo width at or below which an object is detected (20 cm at 50 MHz)
CNT_W, 24, counter and pulse_width width; must hold ECHO_TIMEOUT_CYCLES and HOLDOFF_CYCLES

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run round-robin scan while high
echo  in  NUM_SENSORS  raw echo pins (asynchronous)
trigger  out  NUM_SENSORS  trigger pins, at most one bit high at any time
object_detected  out  NUM_SENSORS  per-sensor latched detection result
timeout_flag  out  NUM_SENSORS  per-sensor latched "last measurement timed out"
meas_valid  out  1  one-cycle strobe: new result for sensor_id
sensor_id  out  clog2(NUM_SENSORS)  slot of current or last measurement
pulse_width  out  CNT_W  echo width in cycles of last measurement

Behaviour:
- Reset (async assert, sync release): state IDLE, slot=0, all outputs 0, counters 0, synchronizer flops 0.
- echo passes through a 2-FF synchronizer per bit. Only the synchronized echo of the current slot is observed; other bits are ignored.
- All outputs are registered.
- IDLE: trigger=0. If enable=1 -> TRIG, counter=0.
- TRIG:
  - trigger[slot]=1 for exactly TRIG_CYCLES consecutive cycles.
  - Then trigger=0 -> WAIT_ECHO, counter=0.
- WAIT_ECHO:
  - Only a rising edge counts (synced echo previously 0, now 1) -> MEASURE, counter=1. An echo already high on entry is ignored until it falls and rises again.
  - If counter reaches ECHO_TIMEOUT_CYCLES -> timeout.
- MEASURE:
  - Counter increments each cycle while synced echo=1.
  - On synced echo=0: pulse_width=counter, object_detected[slot]=(counter<=THRESH_CYCLES), timeout_flag[slot]=0, meas_valid=1 for one cycle -> HOLDOFF.
  - If counter reaches ECHO_TIMEOUT_CYCLES while echo is still high -> timeout.
- Timeout (from either state): pulse_width=ECHO_TIMEOUT_CYCLES, object_detected[slot]=0, timeout_flag[slot]=1, meas_valid=1 for one cycle -> HOLDOFF.
- HOLDOFF:
  - Lasts HOLDOFF_CYCLES cycles.
  - Then slot=slot+1, wrapping NUM_SENSORS-1 -> 0.
  - Next state is TRIG if enable=1, else IDLE.
- sensor_id:
  - Equals slot in every state.
  - Updates on the HOLDOFF exit cycle.
  - On a meas_valid cycle it names the measured sensor.
- enable deasserted mid-cycle: the current TRIG/WAIT/MEASURE/HOLDOFF runs to completion, then IDLE. The slot still advances. No truncated trigger pulse is ever produced.
- Result bits for sensors other than the current slot hold their values.
- Counters saturate; they never wrap.
- Reset mid-operation: trigger drops to 0 asynchronously and all latched results clear.

Test Plan:
Use TRIG_CYCLES=5, ECHO_TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=10, THRESH_CYCLES=40, NUM_SENSORS=4.
1. Reset then enable=1 -> trigger[0] high exactly 5 cycles, other trigger bits 0, sensor_id=0.
2. echo[0] high 30 cycles after trigger -> meas_valid once, pulse_width=30, object_detected[0]=1, timeout_flag[0]=0. Then holdoff 10 cycles and trigger[1] begins.
3. echo[1] high 60 cycles -> pulse_width=60, object_detected[1]=0. Boundary: echo width 40 -> detected=1; width 41 -> detected=0.
4. echo[2] never rises -> meas_valid 100 cycles after trigger end, timeout_flag[2]=1, pulse_width=100. echo[3] stuck high -> timeout after 100 counted cycles, object_detected[3]=0.
5. After slot 3 -> next trigger on bit 0 (wrap). Toggle echo[1] during slot 0 -> no effect on results. Drop enable during MEASURE -> measurement completes, holdoff completes, state returns to IDLE, no further triggers.
6. Assert rst_n=0 during TRIG -> trigger=0 the same cycle, all outputs 0. After release with enable=1 -> scan restarts at slot 0.
